// File: rtl/puzzle_pkg.sv
// Shared constants and types for the 8-puzzle solver datapath.
//   DATA_W         : board/register width (4-bit blank position + 9 x 4-bit tiles)
//   INIT / IDEAL   : start board and goal board
//   TEMP_ADDR      : register holding the working board
//   DIRECTION_ADDR : register holding the move history
//   ckpt_t         : one checkpoint stack entry {working board, move history}
package puzzle_pkg;

    localparam int DATA_W = 40;

    localparam logic [DATA_W-1:0] INIT  = 40'h4_1234_0578_6;
    localparam logic [DATA_W-1:0] IDEAL = 40'h8_1234_5678_0;

    localparam int TEMP_ADDR      = 2;
    localparam int DIRECTION_ADDR = 3;

    typedef logic [2*DATA_W-1:0] ckpt_t;

endpackage

// File: rtl/ckpt_stack.sv
// LIFO of DEPTH entries used to checkpoint the working board and move history.
// A push writes the next free slot, a pop presents the top entry and removes it;
// both are single-cycle. Illegal requests are dropped and flagged.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   push, pop        : requests (asserting both is an error, nothing happens)
//   clr_err          : clears sticky error flags (a new error in the same cycle wins)
//   push_data        : entry saved on an accepted push
//   pop_data         : current top entry (valid when not empty)
//   pop_ok           : an accepted pop this cycle; the parent restores pop_data
//   level/full/empty : occupancy
//   err_ovf/unf/both : sticky push-while-full, pop-while-empty, push-and-pop
module ckpt_stack #(
    parameter int DEPTH = 8,
    parameter int ENT_W = 2 * puzzle_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr_err,
    input  logic [ENT_W-1:0]         push_data,
    output logic [ENT_W-1:0]         pop_data,
    output logic                     pop_ok,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     err_ovf,
    output logic                     err_unf,
    output logic                     err_both
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ENT_W-1:0] mem [DEPTH];
    logic             push_ok;
    logic             set_ovf;
    logic             set_unf;
    logic             set_both;
    logic [PTR_W-1:0] top_idx;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);

    assign push_ok  = push & ~pop & ~full;
    assign pop_ok   = pop & ~push & ~empty;
    assign set_ovf  = push & ~pop & full;
    assign set_unf  = pop & ~push & empty;
    assign set_both = push & pop;

    // When full, the low bits of level wrap to 0, so subtracting one still
    // lands on the last slot; DEPTH is a power of two.
    assign top_idx  = level[PTR_W-1:0] - PTR_W'(1);
    assign pop_data = mem[top_idx];

    // Entry contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[level[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level    <= '0;
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
            err_both <= 1'b0;
        end else begin
            if (push_ok) begin
                level <= level + LVL_W'(1);
            end else if (pop_ok) begin
                level <= level - LVL_W'(1);
            end
            err_ovf  <= set_ovf  | (err_ovf  & ~clr_err);
            err_unf  <= set_unf  | (err_unf  & ~clr_err);
            err_both <= set_both | (err_both & ~clr_err);
        end
    end

endmodule

// File: rtl/puzzle_regfile_ckpt.sv
// Register file for the 8-puzzle solver: NREG x DATA_W storage, N_RD
// asynchronous read ports, one write port, and a checkpoint stack that saves
// and restores the working-board / move-history pair in a single cycle.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   rd_addr / rd_data   : packed read ports, port i uses slice i
//   we/wr_addr/wr_data  : write port (optionally forwarded to the read ports)
//   push, pop, clr_err  : checkpoint stack control
//   stk_level/full/empty: stack occupancy
//   err_ovf/unf/both    : sticky stack error flags
//   comp                : registered reg[CMP_A] == reg[CMP_B] (solved flag)
//   ord                 : live low bits of the move-history register
module puzzle_regfile_ckpt #(
    parameter int                 DATA_W    = puzzle_pkg::DATA_W,
    parameter int                 ADDR_W    = 4,
    parameter int                 N_RD      = 2,
    parameter int                 STK_DEPTH = 8,
    parameter int                 CKPT_A    = puzzle_pkg::TEMP_ADDR,
    parameter int                 CKPT_B    = puzzle_pkg::DIRECTION_ADDR,
    parameter int                 CMP_A     = 2,
    parameter int                 CMP_B     = 1,
    parameter int                 ORD_W     = 34,
    parameter logic [DATA_W-1:0]  INIT0     = puzzle_pkg::INIT,
    parameter logic [DATA_W-1:0]  INIT1     = puzzle_pkg::IDEAL,
    parameter bit                 BYPASS    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_RD*ADDR_W-1:0]       rd_addr,
    output logic [N_RD*DATA_W-1:0]       rd_data,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    output logic [$clog2(STK_DEPTH):0]   stk_level,
    output logic                         stk_full,
    output logic                         stk_empty,
    output logic                         err_ovf,
    output logic                         err_unf,
    output logic                         err_both,
    output logic                         comp,
    output logic [ORD_W-1:0]             ord
);

    import puzzle_pkg::*;

    localparam int                NREG   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] A_ADDR = ADDR_W'(CKPT_A);
    localparam logic [ADDR_W-1:0] B_ADDR = ADDR_W'(CKPT_B);

    logic [DATA_W-1:0]   regs [NREG];
    logic [2*DATA_W-1:0] push_data;
    logic [2*DATA_W-1:0] pop_data;
    logic                pop_ok;
    logic                wr_ok;

    assign push_data = {regs[CKPT_A], regs[CKPT_B]};

    ckpt_stack #(
        .DEPTH (STK_DEPTH),
        .ENT_W (2 * DATA_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .push_data (push_data),
        .pop_data  (pop_data),
        .pop_ok    (pop_ok),
        .level     (stk_level),
        .full      (stk_full),
        .empty     (stk_empty),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_both  (err_both)
    );

    // A restore owns both checkpointed registers for that edge; a write to
    // any other register still goes through.
    assign wr_ok = we & ~(pop_ok & ((wr_addr == A_ADDR) | (wr_addr == B_ADDR)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            regs[0] <= INIT0;
            regs[1] <= INIT1;
            comp    <= 1'b0;
        end else begin
            comp <= (regs[CMP_A] == regs[CMP_B]);
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            if (pop_ok) begin
                regs[CKPT_A] <= pop_data[2*DATA_W-1:DATA_W];
                regs[CKPT_B] <= pop_data[DATA_W-1:0];
            end
        end
    end

    // Forwarding follows the raw write request, even one a pop will drop;
    // restored pop data only shows up after the edge.
    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_data[i*DATA_W +: DATA_W] =
            (BYPASS && we && (wr_addr == addr)) ? wr_data : regs[addr];
    end

    assign ord = regs[CKPT_B][ORD_W-1:0];

endmodule
